// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the E-stage multiply/divide unit.
package md_pkg;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MULT,
        MD_DIV
    } md_state_e;

    localparam logic MD_OP_MUL = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;

    localparam logic HL_SEL_LO = 1'b0;
    localparam logic HL_SEL_HI = 1'b1;

    // Most-negative dividend; /-1 yields itself with zero remainder, no trap.
    localparam logic [31:0] DIVIDE_OVF_NUM = 32'h8000_0000;

    // Magnitude of a 32-bit operand when treated as signed; raw value otherwise.
    function automatic logic [31:0] abs_val(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage <-> multiply/divide unit handshake and HI/LO read-back.
interface mult_div_unit_if;

    logic [31:0] D1;
    logic [31:0] D2;
    logic        Start;
    logic        MD;
    logic        MDSign;
    logic        HLWrite;
    logic        HLSel;
    logic        InterruptRequest;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Div0;

    // Execute stage drives operands and strobes.
    modport master (
        output D1, D2, Start, MD, MDSign, HLWrite, HLSel, InterruptRequest,
        input  Busy, HI, LO, Div0
    );

    // Multiply/divide unit responds.
    modport slave (
        input  D1, D2, Start, MD, MDSign, HLWrite, HLSel, InterruptRequest,
        output Busy, HI, LO, Div0
    );

endinterface

// File: rtl/mult_div_unit_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle. The load cycle already
// performs the first iteration, so 32 bits are resolved after load plus 31 steps.
module md_div_core (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] src_rem, src_quo;
    logic [32:0] shifted, trial;

    // One restoring iteration on either fresh operands (load) or the running state.
    always_comb begin
        src_rem = load_i ? 32'd0 : rem_q;
        src_quo = load_i ? dividend_i : quo_q;
        dvs_d   = load_i ? divisor_i : dvs_q;
        shifted = {src_rem, src_quo[31]};
        trial   = shifted - {1'b0, dvs_d};
        if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {src_quo[30:0], 1'b1};
        end else begin
            rem_d = shifted[31:0];
            quo_d = {src_quo[30:0], 1'b0};
        end
    end

    // Divider state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i || step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU responder owning the architectural HI/LO pair.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    md_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              sign_q, sign_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;

    logic              busy;
    logic              div_by_zero;
    logic              accept;
    logic [63:0]       mul_a, mul_b, product;
    logic [31:0]       div_quo, div_rem;

    assign busy        = (state_q != MD_IDLE);
    assign div_by_zero = (bus.MD == MD_OP_DIV) && (bus.D2 == 32'd0);
    assign accept      = bus.Start && !busy && !bus.InterruptRequest && !div_by_zero;

    // Sign-extend to 64 bits so the low half of an unsigned product is the signed result.
    assign mul_a   = {{32{sign_q & a_q[31]}}, a_q};
    assign mul_b   = {{32{sign_q & b_q[31]}}, b_q};
    assign product = mul_a * mul_b;

    md_div_core u_div_core (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (accept && (bus.MD == MD_OP_DIV)),
        .step_i     (state_q == MD_DIV),
        .dividend_i (abs_val(bus.D1, bus.MDSign)),
        .divisor_i  (abs_val(bus.D2, bus.MDSign)),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    // Next-state: launch on accept, count down, commit HI/LO on the final busy edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    state_d = (bus.MD == MD_OP_DIV) ? MD_DIV : MD_MULT;
                    cnt_d   = (bus.MD == MD_OP_DIV) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                    a_d     = bus.D1;
                    b_d     = bus.D2;
                    sign_d  = bus.MDSign;
                    q_neg_d = bus.MDSign & (bus.D1[31] ^ bus.D2[31]);
                    r_neg_d = bus.MDSign & bus.D1[31];
                end else if (bus.HLWrite && !bus.Start && !bus.InterruptRequest) begin
                    // A Start in the same cycle (even a rejected one) drops the move.
                    if (bus.HLSel == HL_SEL_HI) hi_d = bus.D1;
                    else                        lo_d = bus.D1;
                end
            end
            MD_MULT: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = MD_IDLE;
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                end
            end
            MD_DIV: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = MD_IDLE;
                    hi_d    = r_neg_q ? (~div_rem + 32'd1) : div_rem;
                    lo_d    = q_neg_q ? (~div_quo + 32'd1) : div_quo;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State and architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

    assign bus.Busy = busy;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.Div0 = bus.Start && div_by_zero && !bus.InterruptRequest;

endmodule
